zigzag_sched: RTL and testbench

ZIGZAG_SCHED -- requirements
Module: zigzag_sched

---
 rtl/zigzag_sched.sv | 138 +++++++++++++
 tb/tb_zigzag_sched.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/zigzag_sched.sv
// zigzag_sched: sequences an anti-diagonal (zig-zag) walk over a pw x pd bit-serial tile,
// issuing one step per cycle and flagging diagonal/tile boundaries for the AGU and datapath.
module zigzag_sched #(
    parameter int unsigned BPREC = 4,
    parameter int unsigned BLEN  = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [BPREC-1:0] cfg_pw,
    input  logic [BPREC-1:0] cfg_pd,
    input  logic [BLEN-1:0]  cfg_len,
    input  logic             stall,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             step,
    output logic [BPREC:0]   diag,
    output logic             diag_last,
    output logic             tile_first,
    output logic             tile_last,
    output logic [BLEN-1:0]  tile_idx
);
    localparam int unsigned W = BPREC + 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

    state_t           state_q, state_d;
    logic [BPREC-1:0] pw_q, pw_d, pd_q, pd_d;
    logic [BLEN-1:0]  len_q, len_d, tile_q, tile_d;
    logic [W-1:0]     c_q, c_d, d_q, d_d;
    logic             err_q, err_d;
    logic [W-1:0]     pw_w, pd_w, d_max, rem, diag_len;
    logic             cfg_ok;

    // Diagonal geometry; pw+pd never exceeds 2^W-2, so W bits hold every term without wrap.
    always_comb begin
        pw_w     = {1'b0, pw_q};
        pd_w     = {1'b0, pd_q};
        d_max    = pw_w + pd_w - W'(2);
        rem      = pw_w + pd_w - W'(1) - d_q;
        diag_len = d_q + W'(1);
        if (pw_w < diag_len) diag_len = pw_w;
        if (pd_w < diag_len) diag_len = pd_w;
        if (rem < diag_len)  diag_len = rem;
    end

    // Outputs and next-state logic.
    always_comb begin
        step       = (state_q == StRun) && !stall;
        diag_last  = step && (c_q == diag_len - W'(1));
        tile_first = step && (c_q == '0) && (d_q == '0);
        tile_last  = diag_last && (d_q == d_max);
        busy       = (state_q != StIdle);
        done       = (state_q == StDone);
        err        = err_q;
        diag       = d_q;
        tile_idx   = tile_q;

        state_d = state_q;
        pw_d    = pw_q;
        pd_d    = pd_q;
        len_d   = len_q;
        c_d     = c_q;
        d_d     = d_q;
        tile_d  = tile_q;
        err_d   = 1'b0;
        cfg_ok  = (cfg_pw != '0) && (cfg_pd != '0);

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (!cfg_ok) begin
                        err_d = 1'b1;
                    end else begin
                        pw_d    = cfg_pw;
                        pd_d    = cfg_pd;
                        len_d   = cfg_len;
                        c_d     = '0;
                        d_d     = '0;
                        tile_d  = '0;
                        // An empty job completes immediately without issuing a step.
                        state_d = (cfg_len == '0) ? StDone : StRun;
                    end
                end
            end
            StRun: begin
                if (step) begin
                    if (diag_last) begin
                        c_d = '0;
                        if (tile_last) begin
                            d_d = '0;
                            if (tile_q == len_q - BLEN'(1)) begin
                                state_d = StDone;
                            end else begin
                                tile_d = tile_q + BLEN'(1);
                            end
                        end else begin
                            d_d = d_q + W'(1);
                        end
                    end else begin
                        c_d = c_q + W'(1);
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State register with synchronous clear.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= StIdle;
            pw_q    <= '0;
            pd_q    <= '0;
            len_q   <= '0;
            c_q     <= '0;
            d_q     <= '0;
            tile_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pw_q    <= pw_d;
            pd_q    <= pd_d;
            len_q   <= len_d;
            c_q     <= c_d;
            d_q     <= d_d;
            tile_q  <= tile_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_zigzag_sched.sv
// tb_zigzag_sched: table-driven jobs, hand-written corner sequences and random jobs, each
// checked against a cell-counting model of the zig-zag walk.
module tb_zigzag_sched;
    logic        clk;
    logic        clr;
    logic        start;
    logic [3:0]  cfg_pw;
    logic [3:0]  cfg_pd;
    logic [15:0] cfg_len;
    logic        stall;
    logic        busy;
    logic        done;
    logic        err;
    logic        step;
    logic [4:0]  diag;
    logic        diag_last;
    logic        tile_first;
    logic        tile_last;
    logic [15:0] tile_idx;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int pw;
        int pd;
        int len;
        int stall_pct;
        bit noise;
        int exp_steps;
        int exp_dl;
        bit exp_err;
    } vec_t;

    vec_t vecs [9];
    int   dseq [6] = '{0, 1, 1, 2, 2, 3};
    int   dlseq [6] = '{1, 0, 1, 0, 1, 1};

    zigzag_sched #(.BPREC(4), .BLEN(16)) dut (
        .clk        (clk),
        .clr        (clr),
        .start      (start),
        .cfg_pw     (cfg_pw),
        .cfg_pd     (cfg_pd),
        .cfg_len    (cfg_len),
        .stall      (stall),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .step       (step),
        .diag       (diag),
        .diag_last  (diag_last),
        .tile_first (tile_first),
        .tile_last  (tile_last),
        .tile_idx   (tile_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pack(input int d, input bit dl, input bit tf, input bit tl,
                                         input int t);
        return {8'd0, 5'(d), dl, tf, tl, 16'(t)};
    endfunction

    // Runs one job; the model counts grid cells (i,j) with i+j==d to size each diagonal.
    task automatic run_job(input int pw, input int pd, input int len, input int stall_pct,
                           input bit noise, output int n_steps, output int n_dl,
                           output bit got_err);
        logic [31:0] q[$];
        logic [31:0] act;
        logic [31:0] exp_v;
        int cyc;
        bit got_done;
        n_steps  = 0;
        n_dl     = 0;
        got_err  = 0;
        got_done = 0;
        cyc      = 0;
        if (pw != 0 && pd != 0) begin
            for (int t = 0; t < len; t++) begin
                for (int d = 0; d <= pw + pd - 2; d++) begin
                    int cells = 0;
                    for (int i = 0; i < pw; i++)
                        for (int j = 0; j < pd; j++)
                            if (i + j == d) cells++;
                    for (int c = 0; c < cells; c++)
                        q.push_back(pack(d, c == cells - 1, d == 0 && c == 0,
                                         (c == cells - 1) && (d == pw + pd - 2), t));
                end
            end
        end
        @(negedge clk);
        start   = 1'b1;
        cfg_pw  = 4'(pw);
        cfg_pd  = 4'(pd);
        cfg_len = 16'(len);
        stall   = 1'b0;
        @(negedge clk);
        start = 1'b0;
        if (pw == 0 || pd == 0) begin
            #1;
            got_err = err;
            check("err_busy_low", int'(busy), 0);
            @(negedge clk);
            #1;
            check("err_one_cycle", int'(err), 0);
            return;
        end
        while (!got_done && cyc < 5000) begin
            stall = (int'($urandom_range(99)) < stall_pct);
            if (noise) begin
                start   = 1'($urandom_range(1));
                cfg_pw  = 4'($urandom);
                cfg_pd  = 4'($urandom);
                cfg_len = 16'($urandom);
            end
            #1;
            if (done) begin
                got_done = 1;
                check("done_after_last_step", q.size(), 0);
                check("done_busy", int'(busy), 1);
                check("done_no_step", int'(step), 0);
            end else if (step) begin
                n_steps++;
                if (diag_last) n_dl++;
                check("no_step_when_stalled", int'(stall), 0);
                act = pack(int'(diag), diag_last, tile_first, tile_last, int'(tile_idx));
                check("trace_nonempty", int'(q.size() > 0), 1);
                if (q.size() > 0) begin
                    exp_v = q.pop_front();
                    check("step_trace", int'(act), int'(exp_v));
                end
            end else begin
                check("bubble_only_when_stalled", int'(stall), 1);
                check("flags_gated", int'({diag_last, tile_first, tile_last}), 0);
                check("busy_run", int'(busy), 1);
            end
            @(negedge clk);
            cyc++;
        end
        check("done_seen", int'(got_done), 1);
        start = 1'b0;
        stall = 1'b0;
        #1;
        check("done_one_cycle", int'(done), 0);
        check("idle_busy", int'(busy), 0);
    endtask

    initial begin
        int  ns;
        int  nd;
        int  n;
        int  pw;
        int  pd;
        int  len;
        bit  ge;
        bit  fin;

        vecs[0] = '{2, 3, 1, 0, 0, 6, 4, 0};
        vecs[1] = '{1, 1, 4, 0, 0, 4, 4, 0};
        vecs[2] = '{4, 2, 2, 30, 0, 16, 10, 0};
        vecs[3] = '{3, 5, 3, 40, 1, 45, 21, 0};
        vecs[4] = '{15, 15, 1, 20, 1, 225, 29, 0};
        vecs[5] = '{1, 7, 2, 0, 1, 14, 14, 0};
        vecs[6] = '{0, 3, 1, 0, 0, 0, 0, 1};
        vecs[7] = '{5, 0, 2, 0, 0, 0, 0, 1};
        vecs[8] = '{2, 2, 0, 0, 0, 0, 0, 0};

        clr     = 1'b1;
        start   = 1'b0;
        cfg_pw  = '0;
        cfg_pd  = '0;
        cfg_len = '0;
        stall   = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_outputs", int'({busy, done, err, step, diag_last, tile_first, tile_last,
                                     diag, tile_idx}), 0);
        clr = 1'b0;

        for (int k = 0; k < 9; k++) begin
            run_job(vecs[k].pw, vecs[k].pd, vecs[k].len, vecs[k].stall_pct, vecs[k].noise,
                    ns, nd, ge);
            check("vec_err", int'(ge), int'(vecs[k].exp_err));
            check("vec_steps", ns, vecs[k].exp_steps);
            check("vec_diag_lasts", nd, vecs[k].exp_dl);
        end

        // pw=2, pd=3: explicit diagonal sequence and boundary flags.
        @(negedge clk);
        start = 1'b1; cfg_pw = 4'd2; cfg_pd = 4'd3; cfg_len = 16'd1; stall = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            #1;
            check("seq23_step", int'(step), 1);
            check("seq23_diag", int'(diag), dseq[k]);
            check("seq23_diag_last", int'(diag_last), dlseq[k]);
            check("seq23_tile_last", int'(tile_last), int'(k == 5));
            check("seq23_tile_first", int'(tile_first), int'(k == 0));
            @(negedge clk);
        end
        #1;
        check("seq23_done", int'(done), 1);
        @(negedge clk);

        // pw=4, pd=2: three stalled cycles at the fourth step freeze everything.
        start = 1'b1; cfg_pw = 4'd4; cfg_pd = 4'd2; cfg_len = 16'd1; stall = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("stall_no_step", int'(step), 0);
            check("stall_diag_frozen", int'(diag), 2);
            @(negedge clk);
        end
        stall = 1'b0;
        n   = 3;
        fin = 0;
        for (int k = 0; k < 20 && !fin; k++) begin
            #1;
            if (done) fin = 1;
            else if (step) n++;
            @(negedge clk);
        end
        check("stall_done_seen", int'(fin), 1);
        check("stall_total_steps", n, 8);

        // Clear in the middle of a pw=3, pd=3, len=2 job, with start held high.
        start = 1'b1; cfg_pw = 4'd3; cfg_pd = 4'd3; cfg_len = 16'd2; stall = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        clr = 1'b1; start = 1'b1; stall = 1'b1;
        @(negedge clk);
        clr = 1'b0; start = 1'b0; stall = 1'b0;
        #1;
        check("clr_outputs", int'({busy, done, err, step, diag_last, tile_first, tile_last,
                                   diag, tile_idx}), 0);
        run_job(3, 3, 1, 0, 0, ns, nd, ge);
        check("clr_rerun_steps", ns, 9);
        check("clr_rerun_diag_lasts", nd, 5);

        // Random jobs with random stalls and cfg/start noise while busy.
        for (int r = 0; r < 20; r++) begin
            pw  = ($urandom_range(9) == 0) ? 0 : int'($urandom_range(15, 1));
            pd  = ($urandom_range(9) == 0) ? 0 : int'($urandom_range(15, 1));
            len = int'($urandom_range(2));
            run_job(pw, pd, len, int'($urandom_range(50)), 1'b1, ns, nd, ge);
            check("rand_err", int'(ge), int'(pw == 0 || pd == 0));
            check("rand_steps", ns, (pw == 0 || pd == 0) ? 0 : pw * pd * len);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
